keypad_count_ctrl: RTL



---
 rtl/keypad_ctrl_pkg.sv | 19 +
 rtl/sat_up_counter.sv | 35 +++
 rtl/keypad_count_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/keypad_ctrl_pkg.sv
// Shared types and constants for the keypad-driven counter sequencer.
// Key codes are digit indices on the keypad bus.
package keypad_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        RUN,
        DONE
    } state_e;

    localparam int KEY_W = 4;

    localparam logic [KEY_W-1:0] KEY_CLR  = 4'd0;
    localparam logic [KEY_W-1:0] KEY_STEP = 4'd8;
    localparam logic [KEY_W-1:0] KEY_RSVD = 4'd9;
    localparam logic [KEY_W-1:0] CNT_MAX  = 4'd7;

endpackage

// File: rtl/sat_up_counter.sv
// Unsigned up-counter that sticks at its all-ones value instead of wrapping.
// A clear request takes priority over an increment in the same cycle.
module sat_up_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    logic [CNT_W-1:0] q_q;
    logic [CNT_W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/keypad_count_ctrl.sv
// Keypad front end and command sequencer: edge-detects digit presses, picks the
// lowest-numbered one, and walks a saturating counter toward the requested target.
module keypad_count_ctrl
    import keypad_ctrl_pkg::*;
#(
    parameter int CNT_W = 3,
    parameter int KEYS  = 10
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [KEYS-1:0]  keypad,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             hit4
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             err_q, err_d;
    logic [KEYS-1:0]  prev_q, prev_d;

    logic [KEYS-1:0]  press;
    logic [KEY_W-1:0] win;
    logic [CNT_W-1:0] win_cnt;
    logic             press_any;
    logic             press_multi;
    logic             cnt_clr;
    logic             cnt_inc;

    // Rising-edge detect and lowest-index arbitration over the raw keypad.
    always_comb begin
        prev_d      = keypad;
        press       = keypad & ~prev_q;
        press_multi = (press & (press - KEYS'(1))) != '0;
        win         = '0;
        press_any   = 1'b0;
        for (int k = KEYS - 1; k >= 0; k--) begin
            if (press[k]) begin
                win       = KEY_W'(k);
                press_any = 1'b1;
            end
        end
        win_cnt = win[CNT_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        err_d    = press_any && press_multi;

        case (state_q)
            IDLE: begin
                if (press_any) begin
                    if (win == KEY_CLR) begin
                        target_d = '0;
                        state_d  = CLR;
                    end else if (win <= CNT_MAX) begin
                        target_d = win_cnt;
                        if (win_cnt == count) begin
                            state_d = DONE;
                        end else if (win_cnt > count) begin
                            state_d = RUN;
                        end else begin
                            state_d = CLR;
                        end
                    end else if (win == KEY_STEP) begin
                        cnt_inc = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLR: begin
                cnt_clr = 1'b1;
                state_d = (target_q == '0) ? DONE : RUN;
            end
            RUN: begin
                cnt_inc = 1'b1;
                if ((count + CNT_W'(1)) == target_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An abort restarts the clear sequence from wherever the count sits now.
        if ((state_q != IDLE) && press_any) begin
            if (win == KEY_CLR) begin
                target_d = '0;
                state_d  = CLR;
                cnt_clr  = 1'b0;
                cnt_inc  = 1'b0;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q  <= IDLE;
            target_q <= '0;
            err_q    <= 1'b0;
            prev_q   <= '1;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            err_q    <= err_d;
            prev_q   <= prev_d;
        end
    end

    sat_up_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk  (clk),
        .clear(clear),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .q    (count)
    );

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign err  = err_q;
    assign hit4 = (count == CNT_W'(4));

endmodule
